// File: rtl/regfile_wb_queue_if.sv
// Handshake, register-file write port and forwarding bundle for regfile_wb_queue.
// The queue side uses the slave modport; result producers and decode use master.
interface regfile_wb_queue_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4
);
    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;

    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;

    logic              wb_hold;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_a3;
    logic [DATA_W-1:0] rf_wd;

    logic [ADDR_W-1:0] q1_addr;
    logic [ADDR_W-1:0] q2_addr;
    logic              fwd1_hit;
    logic [DATA_W-1:0] fwd1_data;
    logic              fwd2_hit;
    logic [DATA_W-1:0] fwd2_data;

    logic [ADDR_W:0]   count;
    logic              empty;

    modport master (
        output alu_valid, alu_rd, alu_data,
        input  alu_ready,
        output mem_valid, mem_rd, mem_data,
        input  mem_ready,
        output wb_hold,
        input  rf_we, rf_a3, rf_wd,
        output q1_addr, q2_addr,
        input  fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
        input  count, empty
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        output alu_ready,
        input  mem_valid, mem_rd, mem_data,
        output mem_ready,
        input  wb_hold,
        output rf_we, rf_a3, rf_wd,
        input  q1_addr, q2_addr,
        output fwd1_hit, fwd1_data, fwd2_hit, fwd2_data,
        output count, empty
    );
endinterface

// File: rtl/regfile_wb_queue.sv
// In-order write-back queue for the register file: merges ALU and load results,
// drains one entry per cycle and forwards pending values to the decode read ports.
module regfile_wb_queue #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DEPTH  = 4
) (
    input logic               clk,
    input logic               rst,
    regfile_wb_queue_if.slave bus
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned OCNT_W  = ADDR_W + 1;

    logic [ADDR_W-1:0] rd_mem   [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] free;
    logic             empty;

    logic             mem_acc, alu_acc;
    logic             mem_enq, alu_enq;
    logic             pop;
    logic [PTR_W-1:0] alu_slot;
    logic [PTR_W-1:0] age_idx [DEPTH];

    logic              hit1, hit2;
    logic [DATA_W-1:0] data1, data2;

    // Ready is derived from the registered count only; a same-cycle pop earns no credit.
    always_comb begin
        free          = CNT_W'(DEPTH) - count_q;
        empty         = (count_q == '0);
        bus.mem_ready = (free != '0);
        bus.alu_ready = (free >= CNT_W'(2)) || ((free == CNT_W'(1)) && !bus.mem_valid);
    end

    always_comb begin
        mem_acc  = bus.mem_valid && bus.mem_ready;
        alu_acc  = bus.alu_valid && bus.alu_ready;
        // r0 results complete the handshake but never occupy a slot.
        mem_enq  = mem_acc && (bus.mem_rd != '0);
        alu_enq  = alu_acc && (bus.alu_rd != '0);
        alu_slot = wr_ptr_q + PTR_W'(mem_enq);
        pop      = !empty && !bus.wb_hold && !rst;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(mem_enq) + PTR_W'(alu_enq);
        rd_ptr_d = pop ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + CNT_W'(mem_enq) + CNT_W'(alu_enq) - CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (!rst && mem_enq) begin
            rd_mem[wr_ptr_q]   <= bus.mem_rd;
            data_mem[wr_ptr_q] <= bus.mem_data;
        end
        if (!rst && alu_enq) begin
            rd_mem[alu_slot]   <= bus.alu_rd;
            data_mem[alu_slot] <= bus.alu_data;
        end
    end

    always_comb begin
        bus.rf_we = pop;
        bus.rf_a3 = rd_mem[rd_ptr_q];
        bus.rf_wd = data_mem[rd_ptr_q];
    end

    // Walk entries oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        hit1  = 1'b0;
        hit2  = 1'b0;
        data1 = '0;
        data2 = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            age_idx[i] = rd_ptr_q + PTR_W'(i);
            if (CNT_W'(i) < count_q) begin
                if ((bus.q1_addr != '0) && (rd_mem[age_idx[i]] == bus.q1_addr)) begin
                    hit1  = 1'b1;
                    data1 = data_mem[age_idx[i]];
                end
                if ((bus.q2_addr != '0) && (rd_mem[age_idx[i]] == bus.q2_addr)) begin
                    hit2  = 1'b1;
                    data2 = data_mem[age_idx[i]];
                end
            end
        end
    end

    always_comb begin
        bus.fwd1_hit  = hit1 && !rst;
        bus.fwd1_data = rst ? '0 : data1;
        bus.fwd2_hit  = hit2 && !rst;
        bus.fwd2_data = rst ? '0 : data2;
        bus.count     = OCNT_W'(count_q);
        bus.empty     = empty;
    end

    a_count_bound: assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH))
        else $error("count exceeded DEPTH");
    a_no_overfill: assert property (@(posedge clk) disable iff (rst)
        (count_q == CNT_W'(DEPTH)) |-> (!bus.mem_ready && !bus.alu_ready))
        else $error("ready asserted while full");

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Self-checking bench for regfile_wb_queue: directed scenarios plus a randomised
// run scored against an in-order pending-list model and a register-file image.
module tb_regfile_wb_queue;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 4;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] d;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    ent_t              pend[$];
    logic [DATA_W-1:0] rf_img  [16];
    logic [DATA_W-1:0] ref_img [16];

    regfile_wb_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    regfile_wb_queue #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic idle();
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
    endtask

    // Advance the model with the inputs currently applied, then cross one rising edge.
    task automatic tick();
        int   cnt = pend.size();
        bit   mr, ar, pop;
        ent_t e;
        mr  = (cnt < DEPTH);
        ar  = ((DEPTH - cnt) >= 2) || (((DEPTH - cnt) == 1) && !bus.mem_valid);
        pop = (cnt != 0) && !bus.wb_hold && !rst;
        if (bus.rf_we === 1'b1) rf_img[bus.rf_a3] = bus.rf_wd;
        if (rst) begin
            pend.delete();
        end else begin
            if (pop) begin
                e = pend.pop_front();
                ref_img[e.rd] = e.d;
            end
            if (bus.mem_valid && mr && (bus.mem_rd != 0)) pend.push_back({bus.mem_rd, bus.mem_data});
            if (bus.alu_valid && ar && (bus.alu_rd != 0)) pend.push_back({bus.alu_rd, bus.alu_data});
        end
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_hit(input logic [ADDR_W-1:0] a);
        bit h = 1'b0;
        if (a != 0) foreach (pend[i]) if (pend[i].rd == a) h = 1'b1;
        return h;
    endfunction

    function automatic logic [DATA_W-1:0] model_data(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] d = '0;
        if (a != 0) foreach (pend[i]) if (pend[i].rd == a) d = pend[i].d;
        return d;
    endfunction

    task automatic test_reset();
        idle();
        bus.wb_hold = 1'b0;
        bus.q1_addr = 4'd5;
        bus.q2_addr = 4'd0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", bus.count); end
        total++; if (bus.empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b want=1", bus.empty); end
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b want=0", bus.rf_we); end
        total++; if (bus.fwd1_hit !== 1'b0) begin bad++; $display("FAIL reset_fwd_hit got=%b want=0", bus.fwd1_hit); end
        total++; if (bus.fwd1_data !== 16'h0) begin bad++; $display("FAIL reset_fwd_data got=%h want=0", bus.fwd1_data); end
        total++; if (bus.mem_ready !== 1'b1) begin bad++; $display("FAIL reset_mem_ready got=%b want=1", bus.mem_ready); end
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL reset_alu_ready got=%b want=1", bus.alu_ready); end
    endtask

    task automatic test_single_write();
        idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd3;
        bus.alu_data  = 16'h1234;
        #1;
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL single_ready got=%b want=1", bus.alu_ready); end
        tick();
        idle();
        #1;
        total++; if (bus.rf_we !== 1'b1) begin bad++; $display("FAIL single_we got=%b want=1", bus.rf_we); end
        total++; if (bus.rf_a3 !== 4'd3) begin bad++; $display("FAIL single_a3 got=%0d want=3", bus.rf_a3); end
        total++; if (bus.rf_wd !== 16'h1234) begin bad++; $display("FAIL single_wd got=%h want=1234", bus.rf_wd); end
        total++; if (bus.count !== 5'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", bus.count); end
        tick();
        #1;
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL single_count0 got=%0d want=0", bus.count); end
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL single_we_off got=%b want=0", bus.rf_we); end
    endtask

    task automatic test_dual_order();
        idle();
        bus.wb_hold   = 1'b1;
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 4'd5;
        bus.mem_data  = 16'hAAAA;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd5;
        bus.alu_data  = 16'h5555;
        #1;
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL dual_alu_ready got=%b want=1", bus.alu_ready); end
        tick();
        idle();
        bus.q1_addr = 4'd5;
        #1;
        total++; if (bus.count !== 5'd2) begin bad++; $display("FAIL dual_count got=%0d want=2", bus.count); end
        total++; if (bus.fwd1_hit !== 1'b1) begin bad++; $display("FAIL dual_fwd_hit got=%b want=1", bus.fwd1_hit); end
        total++; if (bus.fwd1_data !== 16'h5555) begin bad++; $display("FAIL dual_fwd_data got=%h want=5555", bus.fwd1_data); end
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL dual_hold_we got=%b want=0", bus.rf_we); end
        bus.wb_hold = 1'b0;
        #1;
        total++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 4'd5, 16'hAAAA}) begin
            bad++; $display("FAIL dual_first got=%b/%0d/%h want=1/5/aaaa", bus.rf_we, bus.rf_a3, bus.rf_wd);
        end
        tick();
        #1;
        total++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 4'd5, 16'h5555}) begin
            bad++; $display("FAIL dual_second got=%b/%0d/%h want=1/5/5555", bus.rf_we, bus.rf_a3, bus.rf_wd);
        end
        tick();
        #1;
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL dual_drained got=%0d want=0", bus.count); end
    endtask

    task automatic test_full_priority();
        idle();
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 4'(i + 1);
            bus.alu_data  = 16'hC000 + 16'(i);
            tick();
        end
        idle();
        bus.mem_valid = 1'b1;
        bus.mem_rd    = 4'd4;
        bus.mem_data  = 16'hC003;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd6;
        bus.alu_data  = 16'hDEAD;
        #1;
        total++; if (bus.count !== 5'd3) begin bad++; $display("FAIL full_count3 got=%0d want=3", bus.count); end
        total++; if (bus.mem_ready !== 1'b1) begin bad++; $display("FAIL full_mem_ready got=%b want=1", bus.mem_ready); end
        total++; if (bus.alu_ready !== 1'b0) begin bad++; $display("FAIL full_alu_prio got=%b want=0", bus.alu_ready); end
        tick();
        idle();
        #1;
        total++; if (bus.count !== 5'd4) begin bad++; $display("FAIL full_count4 got=%0d want=4", bus.count); end
        total++; if ({bus.mem_ready, bus.alu_ready} !== 2'b00) begin
            bad++; $display("FAIL full_readies got=%b%b want=00", bus.mem_ready, bus.alu_ready);
        end
        bus.wb_hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            total++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 4'(i + 1), 16'hC000 + 16'(i)}) begin
                bad++; $display("FAIL full_drain%0d got=%b/%0d/%h want=1/%0d/%h", i, bus.rf_we, bus.rf_a3,
                                bus.rf_wd, i + 1, 16'hC000 + 16'(i));
            end
            tick();
        end
        #1;
        total++; if ({bus.rf_we, bus.empty} !== 2'b01) begin
            bad++; $display("FAIL full_end got=we%b empty%b want=we0 empty1", bus.rf_we, bus.empty);
        end
    endtask

    task automatic test_r0_discard();
        idle();
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd0;
        bus.alu_data  = 16'hFFFF;
        #1;
        total++; if (bus.alu_ready !== 1'b1) begin bad++; $display("FAIL r0_ready got=%b want=1", bus.alu_ready); end
        tick();
        idle();
        bus.q1_addr = 4'd0;
        #1;
        total++; if (bus.count !== 5'd0) begin bad++; $display("FAIL r0_count got=%0d want=0", bus.count); end
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL r0_we got=%b want=0", bus.rf_we); end
        bus.wb_hold   = 1'b1;
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd2;
        bus.alu_data  = 16'h0BAD;
        tick();
        idle();
        bus.q2_addr = 4'd2;
        #1;
        total++; if (bus.fwd1_hit !== 1'b0) begin bad++; $display("FAIL r0_fwd_hit got=%b want=0", bus.fwd1_hit); end
        total++; if ({bus.fwd2_hit, bus.fwd2_data} !== {1'b1, 16'h0BAD}) begin
            bad++; $display("FAIL r0_fwd2 got=%b/%h want=1/0bad", bus.fwd2_hit, bus.fwd2_data);
        end
        bus.wb_hold = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        idle();
        bus.wb_hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.alu_valid = 1'b1;
            bus.alu_rd    = 4'(8 + i);
            bus.alu_data  = 16'h8000 + 16'(i);
            tick();
        end
        idle();
        #1;
        total++; if (bus.count !== 5'd3) begin bad++; $display("FAIL rstmid_pending got=%0d want=3", bus.count); end
        rst = 1'b1;
        bus.wb_hold = 1'b0;
        #1;
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL rstmid_we_during got=%b want=0", bus.rf_we); end
        tick();
        rst = 1'b0;
        #1;
        total++; if ({bus.count, bus.empty, bus.rf_we} !== {5'd0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL rstmid_after got=count%0d empty%b we%b want=count0 empty1 we0",
                            bus.count, bus.empty, bus.rf_we);
        end
        tick();
        tick();
        #1;
        total++; if (bus.rf_we !== 1'b0) begin bad++; $display("FAIL rstmid_quiet got=%b want=0", bus.rf_we); end
        bus.alu_valid = 1'b1;
        bus.alu_rd    = 4'd7;
        bus.alu_data  = 16'hBEEF;
        tick();
        idle();
        #1;
        total++; if ({bus.rf_we, bus.rf_a3, bus.rf_wd} !== {1'b1, 4'd7, 16'hBEEF}) begin
            bad++; $display("FAIL rstmid_new got=%b/%0d/%h want=1/7/beef", bus.rf_we, bus.rf_a3, bus.rf_wd);
        end
        tick();
    endtask

    task automatic test_stress();
        int cnt;
        bit exp_mr, exp_ar, exp_we;
        for (int c = 0; c < 2000; c++) begin
            bus.mem_valid = ($urandom_range(0, 99) < 40);
            bus.mem_rd    = 4'($urandom_range(0, 15));
            bus.mem_data  = 16'($urandom);
            bus.alu_valid = ($urandom_range(0, 99) < 50);
            bus.alu_rd    = 4'($urandom_range(0, 15));
            bus.alu_data  = 16'($urandom);
            bus.wb_hold   = ($urandom_range(0, 99) < 20);
            bus.q1_addr   = 4'($urandom_range(0, 15));
            bus.q2_addr   = 4'($urandom_range(0, 15));
            #1;
            cnt    = pend.size();
            exp_mr = (cnt < DEPTH);
            exp_ar = ((DEPTH - cnt) >= 2) || (((DEPTH - cnt) == 1) && !bus.mem_valid);
            exp_we = (cnt != 0) && !bus.wb_hold;
            total++; if ({bus.mem_ready, bus.alu_ready} !== {exp_mr, exp_ar}) begin
                bad++; $display("FAIL stress_ready c=%0d got=%b%b want=%b%b", c, bus.mem_ready, bus.alu_ready,
                                exp_mr, exp_ar);
            end
            total++; if (bus.rf_we !== exp_we) begin
                bad++; $display("FAIL stress_we c=%0d got=%b want=%b", c, bus.rf_we, exp_we);
            end
            if (exp_we) begin
                total++; if ({bus.rf_a3, bus.rf_wd} !== {pend[0].rd, pend[0].d}) begin
                    bad++; $display("FAIL stress_head c=%0d got=%0d/%h want=%0d/%h", c, bus.rf_a3, bus.rf_wd,
                                    pend[0].rd, pend[0].d);
                end
            end
            total++; if ({bus.count, bus.empty} !== {5'(cnt), cnt == 0}) begin
                bad++; $display("FAIL stress_count c=%0d got=%0d/%b want=%0d", c, bus.count, bus.empty, cnt);
            end
            total++; if ({bus.fwd1_hit, bus.fwd1_data} !== {model_hit(bus.q1_addr), model_data(bus.q1_addr)}) begin
                bad++; $display("FAIL stress_fwd1 c=%0d a=%0d got=%b/%h want=%b/%h", c, bus.q1_addr, bus.fwd1_hit,
                                bus.fwd1_data, model_hit(bus.q1_addr), model_data(bus.q1_addr));
            end
            total++; if ({bus.fwd2_hit, bus.fwd2_data} !== {model_hit(bus.q2_addr), model_data(bus.q2_addr)}) begin
                bad++; $display("FAIL stress_fwd2 c=%0d a=%0d got=%b/%h want=%b/%h", c, bus.q2_addr, bus.fwd2_hit,
                                bus.fwd2_data, model_hit(bus.q2_addr), model_data(bus.q2_addr));
            end
            tick();
        end
        idle();
        bus.wb_hold = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) tick();
        for (int r = 0; r < 16; r++) begin
            total++; if (rf_img[r] !== ref_img[r]) begin
                bad++; $display("FAIL stress_rf_image r%0d got=%h want=%h", r, rf_img[r], ref_img[r]);
            end
        end
    endtask

    initial begin
        for (int r = 0; r < 16; r++) begin
            rf_img[r]  = '0;
            ref_img[r] = '0;
        end
        idle();
        bus.wb_hold = 1'b0;
        bus.q1_addr = '0;
        bus.q2_addr = '0;
        #2;
        test_reset();
        test_single_write();
        test_dual_order();
        test_full_priority();
        test_r0_discard();
        test_reset_mid();
        test_stress();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/regfile_wb_queue.md
Name: regfile_wb_queue

Overview:
- Write-side initiator for the 16-entry x 16-bit core register file. It accepts results from the ALU and load paths over valid/ready handshakes and buffers them in order in a small FIFO.
- It drains one entry per cycle onto the register-file write port (we/A3/wd) and forwards pending (not-yet-written) values to the decode stage's two read addresses so operands are never stale.

Parameters:
- DATA_W, 16, register data width
- ADDR_W, 4, register address width (2^ADDR_W registers)
- DEPTH, 4, FIFO entries; power of 2, >= 2

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous active-high reset
- alu_valid  in  1  ALU result valid
- alu_ready  out  1  queue accepts ALU result this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- mem_valid  in  1  load result valid
- mem_ready  out  1  queue accepts load result this cycle
- mem_rd  in  ADDR_W  load destination register
- mem_data  in  DATA_W  load data
- wb_hold  in  1  1 = suspend draining (debug/stall)
- rf_we  out  1  register-file write enable
- rf_a3  out  ADDR_W  register-file write address
- rf_wd  out  DATA_W  register-file write data
- q1_addr  in  ADDR_W  decode read address 1 (A1)
- q2_addr  in  ADDR_W  decode read address 2 (A2)
- fwd1_hit  out  1  pending write exists for q1_addr
- fwd1_data  out  DATA_W  youngest pending data for q1_addr
- fwd2_hit  out  1  as fwd1, for q2_addr
- fwd2_data  out  DATA_W  as fwd1, for q2_addr
- count  out  ADDR_W+1  occupied entries, 0..DEPTH
- empty  out  1  count == 0

Behaviour:
- Reset: clk and rst are sampled together; rst=1 at a rising edge clears wr_ptr, rd_ptr and count. Pending entries are discarded, including on reset mid-operation. Entry storage need not be cleared.
- Output values during and immediately after reset: rf_we=0, count=0, empty=1, fwd*_hit=0, fwd*_data=0. alu_ready/mem_ready follow the free-slot rule (high once count=0). rf_a3/rf_wd are don't-care while rf_we=0.
- Free slots: free = DEPTH - count, using the registered count only. There is no credit for a same-cycle pop.
- mem_ready = (free >= 1).
- alu_ready = (free >= 2) or (free == 1 and !mem_valid). The load path has priority for the last slot. alu_ready depends combinationally on mem_valid.
- Accept: a source is accepted when valid & ready at a rising edge.
- Register 0 handling: an accepted result with rd == 0 is consumed (handshake completes) but not enqueued, since r0 always reads 0.
- Same-cycle ordering: if both sources are accepted in one cycle, the mem entry is written first (older) and the alu entry second (younger). wr_ptr advances by the number of entries actually enqueued (0, 1 or 2), modulo DEPTH.
- Drain: rf_we = !empty & !wb_hold. rf_a3/rf_wd come combinationally from the head entry.
- Pop timing: the head is popped at the rising edge where rf_we=1, so the register file commits at that same edge. rd_ptr wraps modulo DEPTH.
- Latency: a result accepted at edge k appears on the rf port in cycle k+1 at the earliest (queue empty, no hold) and is committed at edge k+1.
- Count update: count_next = count + enq_n - pop. Simultaneous enqueue and pop are legal. count never exceeds DEPTH and never goes below 0; overflow is impossible by construction of the ready rule.
- Forwarding (combinational): fwdN_hit=1 if qN_addr != 0 and any occupied entry (head included) has rd == qN_addr. fwdN_data = data of the youngest matching entry, else 0. Entries accepted in the current cycle are not visible until after the edge.
- wb_hold: blocks pops only. Acceptance continues until full; at count == DEPTH both readies are 0.

Test Plan:
- Single write: alu_valid, alu_rd=3, alu_data=0x1234 for one cycle on an empty queue -> next cycle rf_we=1, rf_a3=3, rf_wd=0x1234; count returns to 0 after that edge.
- Dual accept plus ordering: mem (rd=5, 0xAAAA) and alu (rd=5, 0x5555) in the same cycle -> count=2. With wb_hold=1: q1_addr=5 gives fwd1_hit=1, fwd1_data=0x5555. Release hold -> rf writes 5/0xAAAA, then 5/0x5555 on consecutive cycles.
- Full/priority: wb_hold=1, fill 3 entries, then both valid -> mem_ready=1, alu_ready=0; after the edge count=4, both readies 0. Release hold -> 4 consecutive writes, correct wrap of rd_ptr.
- r0 discard: alu_rd=0, alu_data=0xFFFF accepted -> count stays 0, rf_we stays 0. q1_addr=0 -> fwd1_hit=0 always.
- Reset mid-operation: 3 entries pending, rst=1 for one edge -> count=0, empty=1, rf_we=0, no further writes. A new accept afterwards writes normally.
- Random stress: 2000 cycles of random valids, random rd/data and random wb_hold. Scoreboard the register-file image from the rf port against an in-order reference model; check the forwarding outputs every cycle against the model's pending list.
